bp_update_sched: RTL and testbench
==================================

Name: bp_update_sched

Overview:
Scheduler between the branch-predictor updater and the single-ported PHT/BTB/BHR storage. It queues resolved-branch updates and arbitrates the table port between fetch-stage lookups and queued writes, with a starvation guard. It also runs the table initialisation sweep after reset or on a clear request. It sits between the AGEX-side updater output and the predictor tables.

Parameters:
PHT_IDX_W, 8, PHT index width (256 entries)
BTB_IDX_W, 4, BTB index width (16 entries)
BTB_ENTRY_W, 59, BTB entry width
QDEPTH, 4, update queue depth (power of 2)
STARVE_MAX, 3, max consecutive cycles a queued head may lose to lookups
PHT_INIT, 2'b01, PHT reset value (weakly not-taken)

Ports:
clk  in  1  clock
reset  in  1  asynchronous, active-high reset
upd_valid  in  1  update offered
upd_is_branch  in  1  update is a branch; non-branch updates are accepted and dropped
upd_taken  in  1  resolved direction; gates BTB write
upd_bhr  in  8  new BHR value
upd_pht_idx  in  PHT_IDX_W  PHT write index
upd_pht_entry  in  2  new PHT counter
upd_btb_idx  in  BTB_IDX_W  BTB write index
upd_btb_entry  in  BTB_ENTRY_W  new BTB entry
upd_ready  out  1  queue can accept
clear_req  in  1  one-cycle pulse: flush queue, re-init tables
lkp_req  in  1  fetch requests table port this cycle
lkp_grant  out  1  lookup owns port this cycle
pht_we  out  1  PHT write enable
pht_waddr  out  PHT_IDX_W  PHT write address
pht_wdata  out  2  PHT write data
btb_we  out  1  BTB write enable
btb_waddr  out  BTB_IDX_W  BTB write address
btb_wdata  out  BTB_ENTRY_W  BTB write data
bhr_we  out  1  BHR write enable
bhr_wdata  out  8  BHR write data
busy  out  1  init sweep in progress
q_count  out  log2(QDEPTH)+1  queue occupancy

Behaviour:
- FSM states are INIT and RUN. On reset assertion: state=INIT, init_ctr=0, queue empty, wait_ctr=0.
- While reset is high, every write enable and lkp_grant is 0.
- INIT: busy=1, upd_ready=0, lkp_grant=0.
  - Each cycle: pht_we=1, pht_waddr=init_ctr, pht_wdata=PHT_INIT.
  - btb_we=1 with btb_wdata=0 while init_ctr<16, btb_waddr=init_ctr[3:0].
  - bhr_we=1 with bhr_wdata=0 when init_ctr==0.
  - init_ctr increments each cycle. The cycle after init_ctr==255 is written, state goes to RUN.
  - The sweep is exactly 256 cycles.
- RUN: busy=0, upd_ready = !full.
- Enqueue: on upd_valid && upd_ready && upd_is_branch, push {taken, bhr, pht_idx, pht_entry, btb_idx, btb_entry}.
  - If upd_is_branch=0, the update is consumed with no push.
- Pushed data is visible at the queue head the next cycle. There is no bypass, so minimum enqueue-to-write latency is 1 cycle.
- force = full || (wait_ctr == STARVE_MAX).
- drain = RUN && !empty && (!lkp_req || force).
- lkp_grant = RUN && lkp_req && !drain. All arbitration outputs are combinational from registered state.
- On drain, the head is popped and written in the same cycle:
  - pht_we=1, pht_waddr/pht_wdata from head.
  - bhr_we=1, bhr_wdata from head.
  - btb_we = head.taken, btb_waddr/btb_wdata from head.
- When not draining in RUN, all write enables are 0.
- wait_ctr: cleared on drain or when the queue is empty. Otherwise it increments while the head is blocked by lkp_req, saturating at STARVE_MAX.
- Simultaneous push and pop: q_count is unchanged, FIFO order is preserved, and push is allowed only when !full before the pop.
- Pointers wrap modulo QDEPTH.
- clear_req in RUN:
  - That cycle: no drain, upd_ready=0, lkp_grant=0.
  - Next cycle: queue emptied, wait_ctr=0, state=INIT, init_ctr=0.
- clear_req in INIT: init_ctr restarts at 0 the next cycle.

Test Plan:
- Release reset -> busy=1 for 256 cycles; pht_waddr 0..255 with data 01; btb_we for indices 0..15 with data 0; bhr_we only in first cycle; then busy=0, upd_ready=1.
- RUN, lkp_req=0, push taken update (pht_idx 0x5A, entry 2'b10, btb_idx 3, bhr 0x81) -> next cycle pht_we=1 to addr 0x5A with data 10; btb_we=1 to idx 3; bhr_wdata=0x81; q_count back to 0.
- Same with upd_taken=0 -> pht_we=1, bhr_we=1, btb_we=0. Update with upd_is_branch=0 -> no writes, q_count stays 0.
- lkp_req held 1, push one update -> lkp_grant=1 for 3 cycles after the head appears; 4th cycle lkp_grant=0 and write occurs; then lkp_grant=1.
- lkp_req held 1, push 4 updates back-to-back -> q_count=4, upd_ready=0, forced drain on the next cycle (lkp_grant=0), upd_ready=1 the following cycle; FIFO order of pht_waddr preserved.
- Two entries queued, pulse clear_req -> no queued entry is ever written; q_count=0; busy=1 and the 256-cycle sweep restarts from address 0.

Source files
------------

// File: rtl/bp_update_sched.sv
// rtl/bp_update_sched.sv - predictor table port scheduler: update queue, lookup arbitration, init sweep
//
// Purpose: queues resolved-branch updates from the updater and shares the
// single-ported PHT/BTB/BHR storage between fetch lookups and queued writes.
// A queued head that keeps losing to lookups is forced through after
// STARVE_MAX cycles, or at once when the queue is full. After reset or a
// clear request the tables are swept to their initial values.
//
// Ports:
//   clk, reset              clock, asynchronous active-high reset
//   upd_*                   update offer from the updater; upd_ready = accepted
//   clear_req               one-cycle pulse: flush queue and re-run the sweep
//   lkp_req / lkp_grant     fetch lookup request / port grant
//   pht_*, btb_*, bhr_*     table write ports
//   busy                    init sweep in progress
//   q_count                 update queue occupancy
module bp_update_sched #(
  parameter int         PHT_IDX_W   = 8,
  parameter int         BTB_IDX_W   = 4,
  parameter int         BTB_ENTRY_W = 59,
  parameter int         QDEPTH      = 4,
  parameter int         STARVE_MAX  = 3,
  parameter logic [1:0] PHT_INIT    = 2'b01,
  localparam int        PTR_W       = $clog2(QDEPTH),
  localparam int        CNT_W       = PTR_W + 1
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   upd_valid,
  input  logic                   upd_is_branch,
  input  logic                   upd_taken,
  input  logic [7:0]             upd_bhr,
  input  logic [PHT_IDX_W-1:0]   upd_pht_idx,
  input  logic [1:0]             upd_pht_entry,
  input  logic [BTB_IDX_W-1:0]   upd_btb_idx,
  input  logic [BTB_ENTRY_W-1:0] upd_btb_entry,
  output logic                   upd_ready,
  input  logic                   clear_req,
  input  logic                   lkp_req,
  output logic                   lkp_grant,
  output logic                   pht_we,
  output logic [PHT_IDX_W-1:0]   pht_waddr,
  output logic [1:0]             pht_wdata,
  output logic                   btb_we,
  output logic [BTB_IDX_W-1:0]   btb_waddr,
  output logic [BTB_ENTRY_W-1:0] btb_wdata,
  output logic                   bhr_we,
  output logic [7:0]             bhr_wdata,
  output logic                   busy,
  output logic [CNT_W-1:0]       q_count
);

  localparam int WAIT_W = $clog2(STARVE_MAX + 1);

  typedef enum logic {ST_INIT, ST_RUN} state_e;

  typedef struct packed {
    logic                   taken;
    logic [7:0]             bhr;
    logic [PHT_IDX_W-1:0]   pht_idx;
    logic [1:0]             pht_entry;
    logic [BTB_IDX_W-1:0]   btb_idx;
    logic [BTB_ENTRY_W-1:0] btb_entry;
  } upd_t;

  state_e               state_q, state_d;
  logic [PHT_IDX_W-1:0] init_ctr_q, init_ctr_d;
  logic [PTR_W-1:0]     wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]     rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]     count_q, count_d;
  logic [WAIT_W-1:0]    wait_q, wait_d;
  upd_t                 mem_q [QDEPTH];
  upd_t                 head;

  logic full, empty, force_drain, push, pop;

  assign head        = mem_q[rd_ptr_q];
  assign full        = (count_q == CNT_W'(QDEPTH));
  assign empty       = (count_q == '0);
  assign force_drain = full || (wait_q == WAIT_W'(STARVE_MAX));
  assign q_count     = count_q;

  always_comb begin
    state_d    = state_q;
    init_ctr_d = init_ctr_q;
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    count_d    = count_q;
    wait_d     = wait_q;
    push       = 1'b0;
    pop        = 1'b0;
    busy       = 1'b0;
    upd_ready  = 1'b0;
    lkp_grant  = 1'b0;
    pht_we     = 1'b0;
    pht_waddr  = '0;
    pht_wdata  = '0;
    btb_we     = 1'b0;
    btb_waddr  = '0;
    btb_wdata  = '0;
    bhr_we     = 1'b0;
    bhr_wdata  = '0;

    unique case (state_q)
      ST_INIT: begin
        busy      = 1'b1;
        pht_we    = 1'b1;
        pht_waddr = init_ctr_q;
        pht_wdata = PHT_INIT;
        // BTB is smaller than the PHT: only the low part of the sweep touches it.
        btb_we    = ((init_ctr_q >> BTB_IDX_W) == '0);
        btb_waddr = init_ctr_q[BTB_IDX_W-1:0];
        bhr_we    = (init_ctr_q == '0);
        init_ctr_d = init_ctr_q + PHT_IDX_W'(1);
        if (init_ctr_q == '1) state_d = ST_RUN;
        if (clear_req) begin
          state_d    = ST_INIT;
          init_ctr_d = '0;
        end
      end

      ST_RUN: begin
        if (clear_req) begin
          // Clear wins over everything this cycle; queued updates are discarded.
          state_d    = ST_INIT;
          init_ctr_d = '0;
          wr_ptr_d   = '0;
          rd_ptr_d   = '0;
          count_d    = '0;
          wait_d     = '0;
        end else begin
          upd_ready = !full;
          pop       = !empty && (!lkp_req || force_drain);
          lkp_grant = lkp_req && !pop;
          // Fullness is judged before this cycle's pop, so a full queue never
          // accepts even while it drains.
          push      = upd_valid && !full && upd_is_branch;

          if (pop) begin
            pht_we    = 1'b1;
            pht_waddr = head.pht_idx;
            pht_wdata = head.pht_entry;
            bhr_we    = 1'b1;
            bhr_wdata = head.bhr;
            btb_we    = head.taken;
            btb_waddr = head.btb_idx;
            btb_wdata = head.btb_entry;
            rd_ptr_d  = rd_ptr_q + PTR_W'(1);
          end
          if (push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
          count_d = count_q + CNT_W'(push) - CNT_W'(pop);

          if (pop || empty) begin
            wait_d = '0;
          end else if (lkp_req && (wait_q != WAIT_W'(STARVE_MAX))) begin
            wait_d = wait_q + WAIT_W'(1);
          end
        end
      end

      default: state_d = ST_INIT;
    endcase

    // Nothing may reach the tables while reset is held.
    if (reset) begin
      pht_we    = 1'b0;
      btb_we    = 1'b0;
      bhr_we    = 1'b0;
      lkp_grant = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= ST_INIT;
      init_ctr_q <= '0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      wait_q     <= '0;
    end else begin
      state_q    <= state_d;
      init_ctr_q <= init_ctr_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      wait_q     <= wait_d;
    end
  end

  // Queue storage carries no reset; occupancy alone says which slots are live.
  always_ff @(posedge clk) begin
    if (push) begin
      mem_q[wr_ptr_q] <= {upd_taken, upd_bhr, upd_pht_idx, upd_pht_entry,
                          upd_btb_idx, upd_btb_entry};
    end
  end

endmodule

// File: tb/tb_bp_update_sched.sv
// tb/tb_bp_update_sched.sv - self-checking bench for bp_update_sched
module tb_bp_update_sched;

  localparam int PW   = 8;
  localparam int BW   = 4;
  localparam int BEW  = 59;
  localparam int QD   = 4;
  localparam int SMAX = 3;

  logic           clk = 1'b0;
  logic           reset = 1'b1;
  logic           upd_valid = 1'b0;
  logic           upd_is_branch = 1'b0;
  logic           upd_taken = 1'b0;
  logic [7:0]     upd_bhr = '0;
  logic [PW-1:0]  upd_pht_idx = '0;
  logic [1:0]     upd_pht_entry = '0;
  logic [BW-1:0]  upd_btb_idx = '0;
  logic [BEW-1:0] upd_btb_entry = '0;
  logic           upd_ready;
  logic           clear_req = 1'b0;
  logic           lkp_req = 1'b0;
  logic           lkp_grant;
  logic           pht_we;
  logic [PW-1:0]  pht_waddr;
  logic [1:0]     pht_wdata;
  logic           btb_we;
  logic [BW-1:0]  btb_waddr;
  logic [BEW-1:0] btb_wdata;
  logic           bhr_we;
  logic [7:0]     bhr_wdata;
  logic           busy;
  logic [2:0]     q_count;

  bp_update_sched #(
    .PHT_IDX_W(PW), .BTB_IDX_W(BW), .BTB_ENTRY_W(BEW),
    .QDEPTH(QD), .STARVE_MAX(SMAX), .PHT_INIT(2'b01)
  ) dut (
    .clk(clk), .reset(reset),
    .upd_valid(upd_valid), .upd_is_branch(upd_is_branch), .upd_taken(upd_taken),
    .upd_bhr(upd_bhr), .upd_pht_idx(upd_pht_idx), .upd_pht_entry(upd_pht_entry),
    .upd_btb_idx(upd_btb_idx), .upd_btb_entry(upd_btb_entry), .upd_ready(upd_ready),
    .clear_req(clear_req), .lkp_req(lkp_req), .lkp_grant(lkp_grant),
    .pht_we(pht_we), .pht_waddr(pht_waddr), .pht_wdata(pht_wdata),
    .btb_we(btb_we), .btb_waddr(btb_waddr), .btb_wdata(btb_wdata),
    .bhr_we(bhr_we), .bhr_wdata(bhr_wdata), .busy(busy), .q_count(q_count)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit             taken;
    logic [7:0]     bhr;
    logic [PW-1:0]  pi;
    logic [1:0]     pe;
    logic [BW-1:0]  bi;
    logic [BEW-1:0] be;
  } ent_t;

  // Reference model: pending updates in arrival order, sweep position,
  // and how many cycles the current head has lost to lookups.
  ent_t mq[$];
  bit   m_init = 1'b1;
  int   m_pos  = 0;
  int   m_lost = 0;

  int vectors = 0;
  int miscompares = 0;

  bit             e_busy, e_ready, e_grant, e_drain;
  bit             e_pht_we, e_btb_we, e_bhr_we;
  logic [PW-1:0]  e_pht_a;
  logic [1:0]     e_pht_d;
  logic [BW-1:0]  e_btb_a;
  logic [BEW-1:0] e_btb_d;
  logic [7:0]     e_bhr_d;
  int             e_count;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic expect_outputs();
    ent_t h;
    int   qn;
    e_busy = 0; e_ready = 0; e_grant = 0; e_drain = 0;
    e_pht_we = 0; e_btb_we = 0; e_bhr_we = 0;
    e_pht_a = '0; e_pht_d = '0; e_btb_a = '0; e_btb_d = '0; e_bhr_d = '0;
    qn = mq.size();
    if (reset) begin
      e_busy = 1;
    end else if (m_init) begin
      e_busy   = 1;
      e_pht_we = 1; e_pht_a = PW'(m_pos); e_pht_d = 2'b01;
      e_btb_we = (m_pos < 16); e_btb_a = BW'(m_pos % 16); e_btb_d = '0;
      e_bhr_we = (m_pos == 0); e_bhr_d = '0;
    end else begin
      e_ready = (qn < QD) && !clear_req;
      e_drain = !clear_req && qn > 0 && (!lkp_req || qn == QD || m_lost >= SMAX);
      e_grant = lkp_req && !clear_req && !e_drain;
      if (e_drain) begin
        h = mq[0];
        e_pht_we = 1; e_pht_a = h.pi; e_pht_d = h.pe;
        e_bhr_we = 1; e_bhr_d = h.bhr;
        e_btb_we = h.taken; e_btb_a = h.bi; e_btb_d = h.be;
      end
    end
    e_count = qn;
  endtask

  task automatic advance_model();
    ent_t e;
    bit   was_empty;
    if (reset || clear_req) begin
      m_init = 1; m_pos = 0; m_lost = 0;
      mq.delete();
    end else if (m_init) begin
      if (m_pos == 255) m_init = 0;
      else m_pos++;
    end else begin
      was_empty = (mq.size() == 0);
      if (e_drain) void'(mq.pop_front());
      if (upd_valid && e_ready && upd_is_branch) begin
        e.taken = upd_taken; e.bhr = upd_bhr; e.pi = upd_pht_idx;
        e.pe = upd_pht_entry; e.bi = upd_btb_idx; e.be = upd_btb_entry;
        mq.push_back(e);
      end
      if (e_drain || was_empty) m_lost = 0;
      else if (lkp_req && m_lost < SMAX) m_lost++;
    end
  endtask

  // One clock: check outputs mid-cycle, then advance the model on the edge.
  task automatic step();
    @(negedge clk);
    expect_outputs();
    chk("busy", 64'(busy), 64'(e_busy));
    chk("upd_ready", 64'(upd_ready), 64'(e_ready));
    chk("lkp_grant", 64'(lkp_grant), 64'(e_grant));
    chk("q_count", 64'(q_count), 64'(e_count));
    chk("pht_we", 64'(pht_we), 64'(e_pht_we));
    chk("btb_we", 64'(btb_we), 64'(e_btb_we));
    chk("bhr_we", 64'(bhr_we), 64'(e_bhr_we));
    if (e_pht_we) begin
      chk("pht_waddr", 64'(pht_waddr), 64'(e_pht_a));
      chk("pht_wdata", 64'(pht_wdata), 64'(e_pht_d));
    end
    if (e_btb_we) begin
      chk("btb_waddr", 64'(btb_waddr), 64'(e_btb_a));
      chk("btb_wdata", 64'(btb_wdata), 64'(e_btb_d));
    end
    if (e_bhr_we) chk("bhr_wdata", 64'(bhr_wdata), 64'(e_bhr_d));
    @(posedge clk);
    advance_model();
    #1;
  endtask

  task automatic offer(input bit br, input bit tk, input logic [7:0] bhr,
                       input logic [PW-1:0] pi, input logic [1:0] pe,
                       input logic [BW-1:0] bi);
    logic [63:0] r;
    r = {$urandom(), $urandom()};
    upd_valid = 1; upd_is_branch = br; upd_taken = tk; upd_bhr = bhr;
    upd_pht_idx = pi; upd_pht_entry = pe; upd_btb_idx = bi; upd_btb_entry = r[BEW-1:0];
  endtask

  initial begin
    logic [31:0] r;
    repeat (3) step();
    reset = 0;
    repeat (258) step();

    // Taken update, no lookups: written the cycle after it is queued.
    offer(1, 1, 8'h81, 8'h5A, 2'b10, 4'd3);
    step();
    upd_valid = 0;
    repeat (2) step();

    // Not-taken update leaves the BTB alone; a non-branch is swallowed.
    offer(1, 0, 8'h42, 8'hC3, 2'b11, 4'd9);
    step();
    upd_valid = 0;
    step();
    offer(0, 1, 8'h11, 8'h22, 2'b00, 4'd1);
    step();
    upd_valid = 0;
    repeat (2) step();

    // Starvation guard with lookups held high.
    lkp_req = 1;
    offer(1, 1, 8'h07, 8'h33, 2'b01, 4'd5);
    step();
    upd_valid = 0;
    repeat (6) step();

    // Fill the queue back-to-back under continuous lookups.
    for (int i = 0; i < 4; i++) begin
      offer(1, i[0], 8'(i + 16), 8'(i * 17 + 1), 2'(i), 4'(i + 8));
      step();
    end
    upd_valid = 0;
    repeat (8) step();

    // Clear with two entries pending: none of them may reach the tables.
    for (int i = 0; i < 2; i++) begin
      offer(1, 1, 8'hE0, 8'(i + 200), 2'b11, 4'(i));
      step();
    end
    upd_valid = 0;
    clear_req = 1;
    step();
    clear_req = 0;
    lkp_req = 0;
    repeat (20) step();

    // Clear during the sweep restarts it from address 0.
    clear_req = 1;
    step();
    clear_req = 0;
    repeat (260) step();

    // Randomised traffic.
    repeat (700) begin
      r = $urandom();
      lkp_req   = ($urandom_range(0, 99) < 60);
      clear_req = ($urandom_range(0, 399) == 0);
      offer($urandom_range(0, 99) < 85, r[0], r[15:8], r[23:16], r[25:24], r[31:28]);
      upd_valid = ($urandom_range(0, 99) < 50);
      step();
    end
    clear_req = 0;
    upd_valid = 0;
    lkp_req = 0;
    repeat (10) step();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
